// File: rtl/eth_rx_hdr_filter.sv
// eth_rx_hdr_filter
// Receives 8-bit AXI-Stream Ethernet frames, strips the 14-byte Ethernet II
// header, filters on destination MAC and forwards the payload as a new 8-bit
// stream. Accepted headers are presented on a valid/ready sideband.
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// clk edge where valid and ready are both high. A source never drops valid or
// changes its payload while valid is high and ready is low. hdr_valid obeys
// this rule: once raised, it and the header fields hold until hdr_ready.
//
// Frame flow:
//   HDR     : rx always ready; bytes 0..13 shifted into the header registers.
//             tlast on any of them -> truncated frame, stay in HDR.
//             Byte 13 without tlast -> filter decision.
//   HDR_OUT : header offered on hdr_valid; rx stalled until hdr_ready.
//   PAYLOAD : combinational pass-through with full backpressure.
//   DROP    : rx always ready, beats discarded until tlast.

module eth_rx_hdr_filter #(
    parameter bit ENABLE_FILTER       = 1'b1,
    parameter bit ACCEPT_BROADCAST    = 1'b1,
    parameter bit ACCEPT_MULTICAST    = 1'b0,
    parameter int RX_TDATA_WIDTH      = 8,
    parameter int PAYLOAD_TDATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [47:0]                    local_mac,

    input  logic [RX_TDATA_WIDTH-1:0]      rx_tdata,
    input  logic                           rx_tvalid,
    output logic                           rx_tready,
    input  logic                           rx_tlast,
    input  logic                           rx_tuser,

    output logic [PAYLOAD_TDATA_WIDTH-1:0] payload_tdata,
    output logic                           payload_tvalid,
    input  logic                           payload_tready,
    output logic                           payload_tlast,
    output logic                           payload_tuser,

    output logic                           hdr_valid,
    input  logic                           hdr_ready,
    output logic [47:0]                    hdr_dest_mac,
    output logic [47:0]                    hdr_src_mac,
    output logic [15:0]                    hdr_ethertype,

    output logic                           stat_frame_dropped,
    output logic                           stat_hdr_truncated,

    output logic [1:0]                     fsm_state
);

    // Both streams are byte-wide; any other width is a configuration error.
    if (RX_TDATA_WIDTH != 8 || PAYLOAD_TDATA_WIDTH != 8) begin : g_width_error
        $error("eth_rx_hdr_filter: both AXI-Stream TDATA widths must be 8");
    end

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        HDR_OUT = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_HDR_BYTE = 4'd13;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    state_t     state;
    logic [3:0] byte_cnt;

    logic       rx_beat;
    logic       dest_is_bcast;
    logic       dest_is_local;
    logic       dest_is_group;
    logic       filter_accept;

    assign fsm_state = state;
    assign rx_beat   = rx_tvalid & rx_tready;

    // Destination classification. The filter is evaluated on the beat that
    // carries byte 13; the destination field has been complete since byte 5,
    // so the registered value already holds every in-flight dest byte.
    always_comb begin
        dest_is_bcast = (hdr_dest_mac == BCAST_MAC);
        dest_is_local = (hdr_dest_mac == local_mac);
        dest_is_group = hdr_dest_mac[40] & ~dest_is_bcast;
        filter_accept = ~ENABLE_FILTER
                      | dest_is_local
                      | (ACCEPT_BROADCAST & dest_is_bcast)
                      | (ACCEPT_MULTICAST & dest_is_group);
    end

    // Stream steering: rx ready and the payload pass-through per state.
    // Ready is forced low while reset is asserted.
    always_comb begin
        rx_tready      = 1'b0;
        payload_tvalid = 1'b0;
        payload_tdata  = rx_tdata;
        payload_tlast  = rx_tlast;
        // The bad-frame flag is only meaningful on the closing beat.
        payload_tuser  = rx_tuser & rx_tlast;
        if (!reset) begin
            case (state)
                HDR: begin
                    rx_tready = 1'b1;
                end
                DROP: begin
                    rx_tready = 1'b1;
                end
                PAYLOAD: begin
                    rx_tready      = payload_tready;
                    payload_tvalid = rx_tvalid;
                end
                default: begin
                    rx_tready = 1'b0;
                end
            endcase
        end
    end

    // Frame FSM: header capture, filter decision, header handoff, payload/drop
    // tracking, plus the registered header sideband and statistics pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= HDR;
            byte_cnt           <= 4'd0;
            hdr_valid          <= 1'b0;
            hdr_dest_mac       <= 48'd0;
            hdr_src_mac        <= 48'd0;
            hdr_ethertype      <= 16'd0;
            stat_frame_dropped <= 1'b0;
            stat_hdr_truncated <= 1'b0;
        end else begin
            stat_frame_dropped <= 1'b0;
            stat_hdr_truncated <= 1'b0;

            case (state)
                HDR: begin
                    if (rx_beat) begin
                        // Big-endian shift into the field the byte belongs to.
                        if (byte_cnt < 4'd6) begin
                            hdr_dest_mac <= {hdr_dest_mac[39:0], rx_tdata[7:0]};
                        end else if (byte_cnt < 4'd12) begin
                            hdr_src_mac <= {hdr_src_mac[39:0], rx_tdata[7:0]};
                        end else begin
                            hdr_ethertype <= {hdr_ethertype[7:0], rx_tdata[7:0]};
                        end

                        if (rx_tlast) begin
                            // Frame ended inside the header, including a frame
                            // with no payload at all.
                            stat_hdr_truncated <= 1'b1;
                            byte_cnt           <= 4'd0;
                        end else if (byte_cnt == LAST_HDR_BYTE) begin
                            byte_cnt <= 4'd0;
                            if (filter_accept) begin
                                hdr_valid <= 1'b1;
                                state     <= HDR_OUT;
                            end else begin
                                stat_frame_dropped <= 1'b1;
                                state              <= DROP;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end

                HDR_OUT: begin
                    if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        state     <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (rx_beat && rx_tlast) begin
                        byte_cnt <= 4'd0;
                        state    <= HDR;
                    end
                end

                DROP: begin
                    if (rx_beat && rx_tlast) begin
                        byte_cnt <= 4'd0;
                        state    <= HDR;
                    end
                end

                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// Self-checking bench for eth_rx_hdr_filter: frame driver, header and payload
// scoreboards, statistics counters, a second instance with multicast enabled.

`timescale 1ns/1ps

module tb_eth_rx_hdr_filter;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [47:0] local_mac;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tready, rx_tlast, rx_tuser;
    logic [7:0]  payload_tdata;
    logic        payload_tvalid, payload_tready, payload_tlast, payload_tuser;
    logic        hdr_valid, hdr_ready;
    logic [47:0] hdr_dest_mac, hdr_src_mac;
    logic [15:0] hdr_ethertype;
    logic        stat_frame_dropped, stat_hdr_truncated;
    logic [1:0]  fsm_state;

    eth_rx_hdr_filter u_dut (
        .clk(clk), .reset(reset), .local_mac(local_mac),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .payload_tdata(payload_tdata), .payload_tvalid(payload_tvalid),
        .payload_tready(payload_tready), .payload_tlast(payload_tlast),
        .payload_tuser(payload_tuser),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_dest_mac(hdr_dest_mac), .hdr_src_mac(hdr_src_mac),
        .hdr_ethertype(hdr_ethertype),
        .stat_frame_dropped(stat_frame_dropped),
        .stat_hdr_truncated(stat_hdr_truncated),
        .fsm_state(fsm_state)
    );

    // ---------------- multicast-enabled instance ----------------
    logic [7:0]  mc_rx_tdata;
    logic        mc_rx_tvalid, mc_rx_tready, mc_rx_tlast, mc_rx_tuser;
    logic [7:0]  mc_payload_tdata;
    logic        mc_payload_tvalid, mc_payload_tlast, mc_payload_tuser;
    logic        mc_hdr_valid;
    logic [47:0] mc_hdr_dest_mac, mc_hdr_src_mac;
    logic [15:0] mc_hdr_ethertype;
    logic        mc_stat_frame_dropped, mc_stat_hdr_truncated;
    logic [1:0]  mc_fsm_state;

    eth_rx_hdr_filter #(.ACCEPT_MULTICAST(1'b1)) u_dut_mc (
        .clk(clk), .reset(reset), .local_mac(local_mac),
        .rx_tdata(mc_rx_tdata), .rx_tvalid(mc_rx_tvalid), .rx_tready(mc_rx_tready),
        .rx_tlast(mc_rx_tlast), .rx_tuser(mc_rx_tuser),
        .payload_tdata(mc_payload_tdata), .payload_tvalid(mc_payload_tvalid),
        .payload_tready(1'b1), .payload_tlast(mc_payload_tlast),
        .payload_tuser(mc_payload_tuser),
        .hdr_valid(mc_hdr_valid), .hdr_ready(1'b1),
        .hdr_dest_mac(mc_hdr_dest_mac), .hdr_src_mac(mc_hdr_src_mac),
        .hdr_ethertype(mc_hdr_ethertype),
        .stat_frame_dropped(mc_stat_frame_dropped),
        .stat_hdr_truncated(mc_stat_hdr_truncated),
        .fsm_state(mc_fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0]   exp_q[$];       // {tuser, tlast, tdata}
    logic [111:0] exp_hdr_q[$];   // {dest, src, ethertype}
    int exp_drop = 0, act_drop = 0;
    int exp_trunc = 0, act_trunc = 0;
    bit rand_tready = 1'b0;

    task automatic check_eq(input string tag, input logic [111:0] act, input logic [111:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_accept(input logic [47:0] d, input bit mc_en);
        bit bcast;
        bcast = (d == 48'hFFFF_FFFF_FFFF);
        return (d == LOCAL_MAC) || bcast || (mc_en && d[40] && !bcast);
    endfunction

    // ---------------- payload tready stimulus ----------------
    initial begin
        payload_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            payload_tready = rand_tready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && payload_tvalid && payload_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("payload_unexpected", 112'(payload_tvalid), 112'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check_eq("payload_beat", 112'({payload_tuser, payload_tlast, payload_tdata}), 112'(e));
            end
        end
        if (!reset && hdr_valid && hdr_ready) begin
            if (exp_hdr_q.size() == 0) begin
                check_eq("hdr_unexpected", 112'(hdr_valid), 112'd0);
            end else begin
                logic [111:0] h;
                h = exp_hdr_q.pop_front();
                check_eq("hdr_fields", {hdr_dest_mac, hdr_src_mac, hdr_ethertype}, h);
            end
        end
        if (!reset && stat_frame_dropped) act_drop++;
        if (!reset && stat_hdr_truncated) act_trunc++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic [7:0] d, input bit last, input bit user, output int stalls);
        rx_tdata  = d;
        rx_tvalid = 1'b1;
        rx_tlast  = last;
        rx_tuser  = user;
        stalls    = 0;
        @(negedge clk);
        while (!rx_tready && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        if (!rx_tready) check_eq("rx_tready_timeout", 112'(rx_tready), 112'd1);
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    // Full frame: header + len payload bytes. hold > 0 keeps hdr_ready low
    // for that many cycles after byte 13 (caller lowers hdr_ready first).
    // reset_at >= 0 asserts reset while that payload byte is presented.
    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                              input logic [15:0] etype, input int len,
                              input bit rand_data, input bit user_last,
                              input int hold, input int reset_at);
        logic [7:0] bytes[$];
        logic [7:0] d;
        bit acc;
        int stalls;
        int last_idx;
        for (int i = 0; i < 6; i++) bytes.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) bytes.push_back(src[47-8*i -: 8]);
        bytes.push_back(etype[15:8]);
        bytes.push_back(etype[7:0]);
        for (int i = 0; i < len; i++) begin
            d = rand_data ? 8'($urandom_range(0, 255)) : 8'(i);
            bytes.push_back(d);
        end
        last_idx = bytes.size() - 1;
        acc = model_accept(dest, 1'b0);
        if (acc) begin
            exp_hdr_q.push_back({dest, src, etype});
            for (int i = 14; i <= last_idx; i++)
                exp_q.push_back({(user_last && i == last_idx), (i == last_idx), bytes[i]});
        end else begin
            exp_drop++;
        end

        for (int idx = 0; idx <= last_idx; idx++) begin
            if (reset_at >= 0 && idx == 14 + reset_at) begin
                rx_tdata  = bytes[idx];
                rx_tvalid = 1'b1;
                reset     = 1'b1;
                @(negedge clk);
                check_eq("rst_rx_tready", 112'(rx_tready), 112'd0);
                check_eq("rst_payload_tvalid", 112'(payload_tvalid), 112'd0);
                @(posedge clk);
                #1;
                reset     = 1'b0;
                rx_tvalid = 1'b0;
                @(negedge clk);
                check_eq("rst_hdr_valid", 112'(hdr_valid), 112'd0);
                check_eq("rst_hdr_fields", {hdr_dest_mac, hdr_src_mac, hdr_ethertype}, 112'd0);
                check_eq("rst_state", 112'(fsm_state), 112'd0);
                check_eq("rst_stats", 112'({stat_frame_dropped, stat_hdr_truncated}), 112'd0);
                check_eq("rst_payload_tvalid_after", 112'(payload_tvalid), 112'd0);
                exp_q.delete();
                @(posedge clk);
                #1;
                return;
            end
            drive_byte(bytes[idx], (idx == last_idx), (user_last && idx == last_idx), stalls);
            if (idx >= 14 && !acc) check_eq("drop_tready", 112'(stalls), 112'd0);
            if (idx == 13) begin
                if (acc && hold > 0) begin
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        check_eq("hold_hdr_valid", 112'(hdr_valid), 112'd1);
                        check_eq("hold_fields", {hdr_dest_mac, hdr_src_mac, hdr_ethertype},
                                 {dest, src, etype});
                        check_eq("hold_rx_tready", 112'(rx_tready), 112'd0);
                    end
                    @(posedge clk);
                    #1;
                    hdr_ready = 1'b1;
                end else if (acc) begin
                    @(negedge clk);
                    check_eq("hdr_latency", 112'(hdr_valid), 112'd1);
                    @(posedge clk);
                    #1;
                end else begin
                    @(negedge clk);
                    check_eq("drop_pulse", 112'(stat_frame_dropped), 112'd1);
                    check_eq("drop_no_hdr", 112'(hdr_valid), 112'd0);
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // Frame of n bytes (n <= 14) ending inside the header.
    task automatic send_short(input int n);
        int stalls;
        exp_trunc++;
        for (int i = 0; i < n; i++)
            drive_byte(8'($urandom_range(0, 255)), (i == n - 1), 1'b0, stalls);
        @(negedge clk);
        check_eq("trunc_pulse", 112'(stat_hdr_truncated), 112'd1);
        check_eq("trunc_no_hdr", 112'(hdr_valid), 112'd0);
        @(posedge clk);
        #1;
    endtask

    // Multicast instance driver: also watches its outputs while waiting.
    bit          mc_hdr_seen = 1'b0;
    logic [47:0] mc_seen_dest = 48'd0;
    int          mc_beats = 0;
    int          mc_drops = 0;

    task automatic mc_observe();
        if (mc_hdr_valid) begin
            mc_hdr_seen  = 1'b1;
            mc_seen_dest = mc_hdr_dest_mac;
        end
        if (mc_payload_tvalid) mc_beats++;
        if (mc_stat_frame_dropped) mc_drops++;
    endtask

    task automatic mc_drive_byte(input logic [7:0] d, input bit last);
        int n;
        mc_rx_tdata  = d;
        mc_rx_tvalid = 1'b1;
        mc_rx_tlast  = last;
        n = 0;
        @(negedge clk);
        mc_observe();
        while (!mc_rx_tready && n < 50) begin
            n++;
            @(negedge clk);
            mc_observe();
        end
        if (!mc_rx_tready) check_eq("mc_tready_timeout", 112'(mc_rx_tready), 112'd1);
        @(posedge clk);
        #1;
        mc_rx_tvalid = 1'b0;
        mc_rx_tlast  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [47:0] mc_dest;
        logic [7:0]  mc_bytes[$];
        int wait_n;

        reset        = 1'b1;
        local_mac    = LOCAL_MAC;
        rx_tdata     = 8'd0;
        rx_tvalid    = 1'b0;
        rx_tlast     = 1'b0;
        rx_tuser     = 1'b0;
        hdr_ready    = 1'b1;
        mc_rx_tdata  = 8'd0;
        mc_rx_tvalid = 1'b0;
        mc_rx_tlast  = 1'b0;
        mc_rx_tuser  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rx_tready", 112'(rx_tready), 112'd0);
        check_eq("reset_payload_tvalid", 112'(payload_tvalid), 112'd0);
        check_eq("reset_hdr_valid", 112'(hdr_valid), 112'd0);
        check_eq("reset_hdr_fields", {hdr_dest_mac, hdr_src_mac, hdr_ethertype}, 112'd0);
        check_eq("reset_stats", 112'({stat_frame_dropped, stat_hdr_truncated}), 112'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_state", 112'(fsm_state), 112'd0);
        check_eq("idle_rx_tready", 112'(rx_tready), 112'd1);
        @(posedge clk);
        #1;

        // Unicast, 46 incrementing payload bytes.
        send_frame(LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 46, 1'b0, 1'b0, 0, -1);

        // Filter reject, then a matching frame.
        send_frame(48'h02_00_00_00_00_02, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 20, 1'b1, 1'b0, 0, -1);
        send_frame(LOCAL_MAC, 48'h11_22_33_44_55_66, 16'h86DD, 8, 1'b1, 1'b0, 0, -1);

        // Broadcast accepted; multicast dropped with default parameters.
        send_frame(48'hFF_FF_FF_FF_FF_FF, 48'h0A_0B_0C_0D_0E_0F, 16'h0806, 28, 1'b1, 1'b0, 0, -1);
        send_frame(48'h01_00_5E_00_00_01, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 12, 1'b1, 1'b0, 0, -1);

        // Truncated frames, then a good one.
        send_short(10);
        send_short(14);
        send_frame(LOCAL_MAC, 48'hA1_A2_A3_A4_A5_A6, 16'h0800, 5, 1'b1, 1'b0, 0, -1);

        // Header backpressure, random payload tready, bad-frame flag on tlast.
        hdr_ready   = 1'b0;
        rand_tready = 1'b1;
        send_frame(LOCAL_MAC, 48'hB0_B1_B2_B3_B4_B5, 16'h88F7, 30, 1'b1, 1'b1, 5, -1);
        send_frame(LOCAL_MAC, 48'hC0_C1_C2_C3_C4_C5, 16'h0800, 40, 1'b1, 1'b0, 0, -1);
        @(posedge clk);
        #1;
        rand_tready = 1'b0;

        // Reset during payload byte 20, then a full frame from byte 0.
        send_frame(LOCAL_MAC, 48'hD0_D1_D2_D3_D4_D5, 16'h0800, 46, 1'b0, 1'b0, 0, 20);
        send_frame(LOCAL_MAC, 48'hE0_E1_E2_E3_E4_E5, 16'h0800, 46, 1'b0, 1'b0, 0, -1);

        // Multicast accepted when enabled.
        mc_dest = 48'h01_00_5E_00_00_01;
        for (int i = 0; i < 6; i++) mc_bytes.push_back(mc_dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) mc_bytes.push_back(8'(8'h20 + i));
        mc_bytes.push_back(8'h08);
        mc_bytes.push_back(8'h00);
        for (int i = 0; i < 3; i++) mc_bytes.push_back(8'(8'h70 + i));
        for (int i = 0; i < mc_bytes.size(); i++)
            mc_drive_byte(mc_bytes[i], (i == mc_bytes.size() - 1));
        repeat (3) begin
            @(negedge clk);
            mc_observe();
        end
        check_eq("mc_hdr_seen", 112'(mc_hdr_seen), 112'd1);
        check_eq("mc_hdr_dest", 112'(mc_seen_dest), 112'(mc_dest));
        check_eq("mc_payload_beats", 112'(mc_beats), 112'd3);
        check_eq("mc_no_drop", 112'(mc_drops), 112'd0);

        // Drain and final accounting.
        wait_n = 0;
        while ((exp_q.size() != 0 || exp_hdr_q.size() != 0) && wait_n < 500) begin
            @(posedge clk);
            wait_n++;
        end
        repeat (2) @(posedge clk);
        check_eq("payload_left", 112'(exp_q.size()), 112'd0);
        check_eq("hdr_left", 112'(exp_hdr_q.size()), 112'd0);
        check_eq("drop_count", 112'(act_drop), 112'(exp_drop));
        check_eq("trunc_count", 112'(act_trunc), 112'(exp_trunc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
